// File: rtl/bus_pkg.sv
// Shared types for the cache bus arbiter: FSM states, bus owner encoding
// and default address/data widths.
package bus_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/cache_bus_arbiter.sv
// Arbitrates I-cache refill and D-cache refill/write-back onto one SRAM-like
// master port, one outstanding transaction at a time, round-robin on conflict.
module cache_bus_arbiter
    import bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_done,
    output logic                i_busy,

    input  logic                d_req,
    input  logic                d_wr,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_done,
    output logic                d_busy,

    output logic                m_req,
    output logic                m_wr,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic                m_addr_ok,
    input  logic                m_data_ok,
    input  logic [DATA_W-1:0]   m_rdata,

    output logic [1:0]          dbg_state_o
);

    localparam int STRB_W = DATA_W / 8;

    // Handshake: a requester holds *_req (and its payload) until it sees the
    // one-cycle *_done pulse and must drop *_req in that same cycle. On the
    // master side the address is transferred in the cycle m_req && m_addr_ok,
    // and the transaction ends in the first cycle m_data_ok is seen in DATA.

    state_t              state_q, state_d;
    owner_t              owner_q;
    owner_t              last_grant_q;
    owner_t              grant;
    logic                any_req;

    logic                m_wr_q;
    logic [ADDR_W-1:0]   m_addr_q;
    logic [DATA_W-1:0]   m_wdata_q;
    logic [STRB_W-1:0]   m_wstrb_q;
    logic                i_done_q, d_done_q;
    logic [DATA_W-1:0]   i_rdata_q, d_rdata_q;

    assign any_req = i_req | d_req;

    // On conflict the port not served last wins; otherwise whoever asks.
    always_comb begin
        grant = OWN_I;
        if (i_req && d_req) begin
            grant = (last_grant_q == OWN_I) ? OWN_D : OWN_I;
        end else if (d_req) begin
            grant = OWN_D;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (any_req)   state_d = ST_ADDR;
            ST_ADDR: if (m_addr_ok) state_d = ST_DATA;
            ST_DATA: if (m_data_ok) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        m_req       = (state_q == ST_ADDR);
        i_busy      = i_req | ((owner_q == OWN_I) && (state_q != ST_IDLE));
        d_busy      = d_req | ((owner_q == OWN_D) && (state_q != ST_IDLE));
        dbg_state_o = state_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q      <= OWN_I;
            last_grant_q <= OWN_I;
            m_wr_q       <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            m_wstrb_q    <= '0;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            if (state_q == ST_IDLE && any_req) begin
                owner_q <= grant;
                if (grant == OWN_D) begin
                    m_wr_q    <= d_wr;
                    m_addr_q  <= d_addr;
                    m_wdata_q <= d_wdata;
                    m_wstrb_q <= d_wstrb;
                end else begin
                    m_wr_q    <= 1'b0;
                    m_addr_q  <= i_addr;
                    m_wdata_q <= '0;
                    m_wstrb_q <= '0;
                end
            end
            if (state_q == ST_DATA && m_data_ok) begin
                last_grant_q <= owner_q;
                if (owner_q == OWN_I) begin
                    i_done_q  <= 1'b1;
                    i_rdata_q <= m_rdata;
                end else begin
                    d_done_q  <= 1'b1;
                    d_rdata_q <= m_rdata;
                end
            end
        end
    end

    assign m_wr    = m_wr_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_wstrb = m_wstrb_q;
    assign i_done  = i_done_q;
    assign d_done  = d_done_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

    // A slave must never return data in the address-accept cycle.
    a_no_addr_and_data_together: assert property (
        @(posedge clk) disable iff (rst)
        !(state_q == ST_ADDR && m_addr_ok && m_data_ok)
    );

endmodule

// File: doc/cache_bus_arbiter.md
# cache_bus_arbiter

Arbitrates the I-cache refill port and the D-cache refill/write-back port onto the single SRAM-like master port in front of the AXI bridge. It allows one outstanding transaction at a time and owns the full request → address-accept → data-return sequence. Its per-port `busy` outputs are the raw sources of `i_stall` and `d_stall` consumed by the pipeline hazard logic.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width (one word per transaction)

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `i_req`  in  1  I-cache read request; held until `i_done`
- `i_addr`  in  ADDR_W  I-cache word address
- `i_rdata`  out  DATA_W  read data, valid with `i_done`
- `i_done`  out  1  one-cycle completion pulse
- `i_busy`  out  1  I request pending or in flight
- `d_req`  in  1  D-cache request; held until `d_done`
- `d_wr`  in  1  1 = write, 0 = read
- `d_addr`  in  ADDR_W  D-cache word address
- `d_wdata`  in  DATA_W  write data
- `d_wstrb`  in  DATA_W/8  byte strobes
- `d_rdata`  out  DATA_W  read data, valid with `d_done`
- `d_done`  out  1  one-cycle completion pulse
- `d_busy`  out  1  D request pending or in flight
- `m_req`  out  1  master request
- `m_wr`  out  1  master write flag
- `m_addr`  out  ADDR_W  master address
- `m_wdata`  out  DATA_W  master write data
- `m_wstrb`  out  DATA_W/8  master strobes
- `m_addr_ok`  in  1  address accepted this cycle while `m_req` is high
- `m_data_ok`  in  1  read data returned or write completed
- `m_rdata`  in  DATA_W  master read data

## Operation
- FSM states: IDLE, ADDR, DATA. Reset to IDLE.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant that port.
  - Both requests: grant the port not served last (`last_grant` register, reset value = I, so the first conflict goes to D).
  - On grant: latch the granted port's addr/wr/wdata/wstrb into master registers, set `owner`, go to ADDR.
- ADDR: `m_req`=1. On `m_addr_ok`, drop `m_req` in the same cycle it samples high and go to DATA.
- DATA: wait for `m_data_ok`.
  - On `m_data_ok`: pulse the owner's `*_done` next cycle with `*_rdata` = registered `m_rdata`, update `last_grant`, go to IDLE.
- I-port transactions always have `m_wr`=0, `m_wstrb`=0.
- D writes: `d_done` pulses on write completion; `d_rdata` is don't-care.
- `m_data_ok` in IDLE or ADDR is ignored. Stale responses after reset are discarded.
- Requester inputs are not re-sampled after grant. A requester changing address mid-flight has no effect.
- A requester must deassert `req` in the cycle `done` is seen. If `req` is still high in the cycle after `done`, it is treated as a new request.
- `*_busy` = `*_req` OR (owner == port AND state != IDLE). It is combinational, so the stall can assert in the same cycle as the request.
- Reset mid-operation: state → IDLE, all outputs to reset values, `last_grant` → I.

## Timing
- Reset values: `m_req`=0, `m_wr`=0, `m_addr`=0, `m_wdata`=0, `m_wstrb`=0, `i_done`=`d_done`=0, `i_rdata`=`d_rdata`=0.
- Request sampled in IDLE at cycle t → `m_req` high at t+1.
- `m_addr_ok` at t+k → `m_req` low at t+k+1.
- `m_data_ok` at cycle u → `*_done` high at u+1 for exactly one cycle, FSM in IDLE at u+1.
  - A new grant can be sampled at u+1, giving `m_req` at u+2.
- Minimum latency with zero-wait slave (`addr_ok` same cycle, `data_ok` next cycle): request at t → `done` at t+3.
- `m_addr_ok` and `m_data_ok` in the same cycle while in ADDR: accept only the address. The slave must not do this; flag it with an assertion.

## Structure
- Shared package `bus_pkg`:
  - state enum (IDLE/ADDR/DATA)
  - owner encoding (`OWN_I`=0, `OWN_D`=1)
  - `ADDR_W`/`DATA_W` defaults
- Single module. No sub-module needed; the round-robin pick is a few lines inline.

## Test plan
- I read alone, zero-wait slave, `i_addr`=0xBFC00000, `m_rdata`=0x3C08BFAF → `m_req` at t+1, `i_done` at t+3, `i_rdata`=0x3C08BFAF, `d_done` stays 0.
- D write, `d_addr`=0x80001000, `d_wdata`=0x12345678, `d_wstrb`=0xF, 3-cycle `addr_ok` delay → `m_wr`=1 with those values held stable until `addr_ok`, then `d_done` one cycle after `data_ok`.
- `i_req` and `d_req` rise together from reset → D served first. With I still requesting and D re-requesting immediately, the next grant goes to I. Alternation holds over 4 transactions.
- `m_data_ok` pulse injected while in IDLE → no `done` pulse, state unchanged.
- `rst` asserted in DATA state with D owning the bus → next cycle `m_req`=0, no `d_done`. A late `m_data_ok` afterwards is ignored. The next `i_req` goes through normally.
- `i_busy`/`d_busy` checks: high in the same cycle as `req`, low in the cycle after `done` once `req` has dropped.
